// File: rtl/syndrome_frame_serializer.sv
// syndrome_frame_serializer
//   Takes one decoding shot, which holds every measurement round, as a parallel
//   syndrome vector. It serializes that shot onto an 8-bit valid/ready byte
//   stream that feeds the decoder input FIFO.
//   After reset the block sends START_MSG once. For each shot after that it sends
//   MEAS_HDR, followed by the payload. In the payload each round is zero-padded up
//   to a whole number of bytes.
//   Once a frame has gone out, the block waits for result_done before it accepts
//   the next shot.
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   shot_data/valid/ready   parallel shot input (valid/ready)
//   out_data/valid/ready    byte stream to decoder input FIFO (registered)
//   result_done      1-cycle pulse: decoder finished result for current shot
//   busy             shot in flight (header, payload or waiting for result)
//   shots_sent       completed frames, wraps at 2^16
//   protocol_error   sticky: result_done outside the wait state
//
// state   | meaning
// S_START | presenting START_MSG, entered only from reset
// S_IDLE  | ready for a shot
// S_HDR   | presenting MEAS_HDR
// S_PAY   | presenting payload byte byte_idx
// S_WAIT  | frame sent, waiting for result_done
module syndrome_frame_serializer #(
   parameter int         GRID_WIDTH_X = 4,
   parameter int         GRID_WIDTH_Z = 1,
   parameter int         GRID_WIDTH_U = 3,
   parameter logic [7:0] START_MSG    = 8'h01,
   parameter logic [7:0] MEAS_HDR     = 8'h02
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] shot_data,
   input  logic                                         shot_valid,
   output logic                                         shot_ready,
   output logic [7:0]                                   out_data,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   input  logic                                         result_done,
   output logic                                         busy,
   output logic [15:0]                                  shots_sent,
   output logic                                         protocol_error
);

   localparam int PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z;
   localparam int BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3;
   localparam int ALIGNED         = BYTES_PER_ROUND * 8;
   localparam int FRAME_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U;
   localparam int IDX_W           = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_IDLE  = 3'd1,
      S_HDR   = 3'd2,
      S_PAY   = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   state_t                         state, state_next;
   logic [IDX_W-1:0]               byte_idx, byte_idx_next;
   logic [FRAME_BYTES-1:0][7:0]    shot_buf;
   logic [FRAME_BYTES*8-1:0]       padded;
   logic                           xfer;
   logic                           capture;
   logic                           frame_done;
   logic                           out_valid_next;
   logic [7:0]                     out_data_next;

   // Each round starts on a byte boundary. The unused high bits of a round stay 0.
   always_comb begin
      padded = '0;
      for (int k = 0; k < GRID_WIDTH_U; k++) begin
         for (int p = 0; p < PU_PER_ROUND; p++) begin
            padded[k*ALIGNED + p] = shot_data[k*PU_PER_ROUND + p];
         end
      end
   end

   assign xfer       = out_valid & out_ready;
   assign shot_ready = (state == S_IDLE);
   assign busy       = (state == S_HDR) || (state == S_PAY) || (state == S_WAIT);

   always_comb begin
      state_next    = state;
      byte_idx_next = byte_idx;
      capture       = 1'b0;
      frame_done    = 1'b0;
      case (state)
         S_START: if (xfer) state_next = S_IDLE;
         S_IDLE: begin
            if (shot_valid) begin
               capture       = 1'b1;
               byte_idx_next = '0;
               state_next    = S_HDR;
            end
         end
         S_HDR: if (xfer) state_next = S_PAY;
         S_PAY: begin
            if (xfer) begin
               if (byte_idx == IDX_W'(FRAME_BYTES - 1)) begin
                  frame_done = 1'b1;
                  state_next = S_WAIT;
               end else begin
                  byte_idx_next = byte_idx + IDX_W'(1);
               end
            end
         end
         S_WAIT: if (result_done) state_next = S_IDLE;
         default: state_next = S_START;
      endcase
   end

   // Output register is loaded from the next state. Data therefore holds
   // naturally while stalled, and bytes follow back to back when out_ready stays high.
   always_comb begin
      out_valid_next = 1'b0;
      out_data_next  = out_data;
      case (state_next)
         S_START: begin out_valid_next = 1'b1; out_data_next = START_MSG; end
         S_HDR:   begin out_valid_next = 1'b1; out_data_next = MEAS_HDR;  end
         S_PAY:   begin out_valid_next = 1'b1; out_data_next = shot_buf[byte_idx_next]; end
         default: out_valid_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_START;
         byte_idx       <= '0;
         shot_buf       <= '0;
         out_valid      <= 1'b0;
         out_data       <= 8'h00;
         shots_sent     <= 16'h0000;
         protocol_error <= 1'b0;
      end else begin
         state     <= state_next;
         byte_idx  <= byte_idx_next;
         out_valid <= out_valid_next;
         out_data  <= out_data_next;
         if (capture) shot_buf <= padded;
         if (frame_done) shots_sent <= shots_sent + 16'd1;
         if (result_done && (state != S_WAIT)) protocol_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_syndrome_frame_serializer.sv
// tb_syndrome_frame_serializer
//   Directed bench for syndrome_frame_serializer. It runs two instances: the
//   default geometry (4x1x3) and a 6x2x2 geometry, which exercises round padding.
//   Inputs are driven and outputs are sampled on the falling clock edge.
module tb_syndrome_frame_serializer;

   logic        clk = 1'b0;
   logic        reset;

   logic [11:0] shot_data_a;
   logic        shot_valid_a, shot_ready_a;
   logic [7:0]  out_data_a;
   logic        out_valid_a, out_ready_a, result_done_a, busy_a, protocol_error_a;
   logic [15:0] shots_sent_a;

   logic [23:0] shot_data_b;
   logic        shot_valid_b, shot_ready_b;
   logic [7:0]  out_data_b;
   logic        out_valid_b, out_ready_b, result_done_b, busy_b, protocol_error_b;
   logic [15:0] shots_sent_b;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  rx [16];
   int          rx_cyc [16];
   int          rx_cnt;

   always #5 clk = ~clk;

   syndrome_frame_serializer dut_a (
      .clk(clk), .reset(reset),
      .shot_data(shot_data_a), .shot_valid(shot_valid_a), .shot_ready(shot_ready_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .result_done(result_done_a), .busy(busy_a), .shots_sent(shots_sent_a),
      .protocol_error(protocol_error_a)
   );

   syndrome_frame_serializer #(.GRID_WIDTH_X(6), .GRID_WIDTH_Z(2), .GRID_WIDTH_U(2)) dut_b (
      .clk(clk), .reset(reset),
      .shot_data(shot_data_b), .shot_valid(shot_valid_b), .shot_ready(shot_ready_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .result_done(result_done_b), .busy(busy_b), .shots_sent(shots_sent_b),
      .protocol_error(protocol_error_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Collect n bytes from dut_a. Transfers are decided at the falling edge and complete
   // on the following rising edge. While a byte is stalled, the output must not change.
   task automatic recv_a(input int n, input bit stall);
      int         budget = 0;
      bit         was_stalled = 1'b0;
      logic [7:0] held = 8'h00;
      rx_cnt = 0;
      while (rx_cnt < n && budget < 300) begin
         @(negedge clk);
         budget++;
         if (was_stalled) begin
            check_val("stall_valid", {31'd0, out_valid_a}, 32'd1);
            check_val("stall_data", {24'd0, out_data_a}, {24'd0, held});
         end
         out_ready_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         was_stalled = 1'b0;
         if (out_valid_a && out_ready_a) begin
            rx[rx_cnt]     = out_data_a;
            rx_cyc[rx_cnt] = budget;
            rx_cnt++;
         end else if (out_valid_a) begin
            was_stalled = 1'b1;
            held        = out_data_a;
         end
      end
      if (rx_cnt != n) check_val("recv_timeout", rx_cnt, n);
      @(negedge clk);
      out_ready_a = 1'b0;
   endtask

   task automatic send_shot_a(input logic [11:0] data);
      int budget = 0;
      while (!shot_ready_a && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check_val("shot_ready_wait", {31'd0, shot_ready_a}, 32'd1);
      shot_data_a  = data;
      shot_valid_a = 1'b1;
      @(negedge clk);
      shot_valid_a = 1'b0;
   endtask

   task automatic pulse_done_a();
      result_done_a = 1'b1;
      @(negedge clk);
      result_done_a = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
      check_val({tag, "_hdr"}, {24'd0, rx[0]}, 32'h02);
      check_val({tag, "_b0"},  {24'd0, rx[1]}, {24'd0, b0});
      check_val({tag, "_b1"},  {24'd0, rx[2]}, {24'd0, b1});
      check_val({tag, "_b2"},  {24'd0, rx[3]}, {24'd0, b2});
      check_val({tag, "_b3"},  {24'd0, rx[4]}, {24'd0, b3});
   endtask

   initial begin
      reset         = 1'b1;
      shot_data_a   = '0; shot_valid_a = 1'b0; out_ready_a = 1'b1; result_done_a = 1'b0;
      shot_data_b   = '0; shot_valid_b = 1'b0; out_ready_b = 1'b1; result_done_b = 1'b0;

      // 1: reset state, then START_MSG, then idle
      repeat (3) @(negedge clk);
      check_val("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
      check_val("rst_out_data", {24'd0, out_data_a}, 32'd0);
      check_val("rst_shot_ready", {31'd0, shot_ready_a}, 32'd0);
      check_val("rst_busy", {31'd0, busy_a}, 32'd0);
      check_val("rst_shots_sent", {16'd0, shots_sent_a}, 32'd0);
      check_val("rst_perr", {31'd0, protocol_error_a}, 32'd0);
      reset = 1'b0;
      recv_a(1, 1'b0);
      check_val("start_msg", {24'd0, rx[0]}, 32'h01);
      check_val("idle_shot_ready", {31'd0, shot_ready_a}, 32'd1);
      check_val("idle_out_valid", {31'd0, out_valid_a}, 32'd0);
      repeat (3) @(negedge clk);
      check_val("idle_hold_valid", {31'd0, out_valid_a}, 32'd0);

      // 2: default frame, no stalls
      send_shot_a(12'hA53);
      check_val("acc_busy", {31'd0, busy_a}, 32'd1);
      check_val("acc_shot_ready", {31'd0, shot_ready_a}, 32'd0);
      check_val("acc_hdr_valid", {31'd0, out_valid_a}, 32'd1);
      recv_a(4, 1'b0);
      check_val("c2_hdr", {24'd0, rx[0]}, 32'h02);
      check_val("c2_b0", {24'd0, rx[1]}, 32'h03);
      check_val("c2_b1", {24'd0, rx[2]}, 32'h05);
      check_val("c2_b2", {24'd0, rx[3]}, 32'h0A);
      check_val("c2_no_bubble", rx_cyc[3] - rx_cyc[0], 32'd3);
      check_val("c2_shots_sent", {16'd0, shots_sent_a}, 32'd1);
      check_val("c2_busy_wait", {31'd0, busy_a}, 32'd1);
      check_val("c2_wait_valid", {31'd0, out_valid_a}, 32'd0);
      pulse_done_a();
      check_val("c2_ready_after_done", {31'd0, shot_ready_a}, 32'd1);
      check_val("c2_perr", {31'd0, protocol_error_a}, 32'd0);

      // 3: 6x2x2 geometry, 12 PUs per round padded to 16 bits
      begin : case3
         int budget = 0;
         int cnt = 0;
         check_val("b_idle", {31'd0, shot_ready_b}, 32'd1);
         shot_data_b  = 24'hFFF_FFF;
         shot_valid_b = 1'b1;
         @(negedge clk);
         shot_valid_b = 1'b0;
         while (cnt < 5 && budget < 50) begin
            if (out_valid_b) begin
               rx[cnt] = out_data_b;
               cnt++;
            end
            @(negedge clk);
            budget++;
         end
         if (cnt != 5) check_val("b_timeout", cnt, 5);
         check_frame("c3", 8'hFF, 8'h0F, 8'hFF, 8'h0F);
         check_val("c3_shots_sent", {16'd0, shots_sent_b}, 32'd1);
      end

      // 4: same shot with random backpressure
      send_shot_a(12'hA53);
      recv_a(4, 1'b1);
      check_val("c4_hdr", {24'd0, rx[0]}, 32'h02);
      check_val("c4_b0", {24'd0, rx[1]}, 32'h03);
      check_val("c4_b1", {24'd0, rx[2]}, 32'h05);
      check_val("c4_b2", {24'd0, rx[3]}, 32'h0A);
      check_val("c4_shots_sent", {16'd0, shots_sent_a}, 32'd2);
      pulse_done_a();

      // 5: early result_done during payload flags an error but leaves the frame intact
      send_shot_a(12'h5C7);
      recv_a(2, 1'b0);
      check_val("c5_hdr", {24'd0, rx[0]}, 32'h02);
      check_val("c5_b0", {24'd0, rx[1]}, 32'h07);
      pulse_done_a();
      check_val("c5_perr", {31'd0, protocol_error_a}, 32'd1);
      check_val("c5_still_valid", {31'd0, out_valid_a}, 32'd1);
      check_val("c5_still_data", {24'd0, out_data_a}, 32'h0C);
      recv_a(2, 1'b0);
      check_val("c5_b1", {24'd0, rx[0]}, 32'h0C);
      check_val("c5_b2", {24'd0, rx[1]}, 32'h05);
      check_val("c5_shots_sent", {16'd0, shots_sent_a}, 32'd3);
      check_val("c5_wait_ready", {31'd0, shot_ready_a}, 32'd0);
      pulse_done_a();
      check_val("c5_ready_next", {31'd0, shot_ready_a}, 32'd1);
      check_val("c5_perr_sticky", {31'd0, protocol_error_a}, 32'd1);

      // 6: reset mid-frame, then restart
      send_shot_a(12'h123);
      recv_a(3, 1'b0);
      check_val("c6_b1", {24'd0, rx[2]}, 32'h02);
      reset = 1'b1;
      @(negedge clk);
      check_val("c6_rst_valid", {31'd0, out_valid_a}, 32'd0);
      check_val("c6_rst_shots", {16'd0, shots_sent_a}, 32'd0);
      check_val("c6_rst_perr", {31'd0, protocol_error_a}, 32'd0);
      check_val("c6_rst_busy", {31'd0, busy_a}, 32'd0);
      @(negedge clk);
      check_val("c6_rst_valid2", {31'd0, out_valid_a}, 32'd0);
      reset = 1'b0;
      recv_a(1, 1'b0);
      check_val("c6_start", {24'd0, rx[0]}, 32'h01);
      check_val("c6_idle", {31'd0, shot_ready_a}, 32'd1);
      send_shot_a(12'h9E4);
      recv_a(4, 1'b0);
      check_val("c6_hdr", {24'd0, rx[0]}, 32'h02);
      check_val("c6_n0", {24'd0, rx[1]}, 32'h04);
      check_val("c6_n1", {24'd0, rx[2]}, 32'h0E);
      check_val("c6_n2", {24'd0, rx[3]}, 32'h09);
      check_val("c6_shots_sent", {16'd0, shots_sent_a}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
